// File: rtl/axi_refill_ctrl.sv
// Refill sequencer: round-robin arbitration of ICache/DCache read misses onto one
// AXI read channel, forwarding each R beat to the owning cache in the same cycle.
module axi_refill_ctrl #(
   parameter int ADDR_W     = 32,
   parameter int LINE_BEATS = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_uncache,
   input  logic              d_req,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic              d_uncache,
   output logic              i_ret_valid,
   output logic              i_ret_last,
   output logic              d_ret_valid,
   output logic              d_ret_last,
   output logic [31:0]       ret_data,
   output logic              ar_valid,
   output logic [ADDR_W-1:0] ar_addr,
   output logic [7:0]        ar_len,
   output logic [2:0]        ar_size,
   input  logic              ar_ready,
   input  logic              r_valid,
   input  logic              r_last,
   input  logic [31:0]       r_data,
   output logic              r_ready,
   output logic              busy,
   output logic              err
);

   // A transfer happens on a posedge where valid and ready are both high; once
   // raised, ar_valid and its payload hold until that cycle.
   localparam logic [7:0] LINE_LEN = 8'(LINE_BEATS - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_AR, ST_R, ST_DONE} state_t;

   state_t            state;
   logic              owner_d;
   logic              last_d;
   logic [7:0]        beat_cnt;
   logic              grant_d;
   logic [ADDR_W-1:0] g_addr;
   logic              g_unc;
   logic              beat;

   // Under contention the requester that did not win last time is granted.
   always_comb begin
      grant_d = d_req && (!i_req || !last_d);
      g_addr  = grant_d ? d_addr : i_addr;
      g_unc   = grant_d ? d_uncache : i_uncache;
   end

   assign beat        = r_ready && r_valid;
   assign ret_data    = r_data;
   assign i_ret_valid = beat && !owner_d;
   assign d_ret_valid = beat && owner_d;
   assign i_ret_last  = i_ret_valid && r_last;
   assign d_ret_last  = d_ret_valid && r_last;
   assign ar_size     = 3'b010;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         owner_d  <= 1'b0;
         last_d   <= 1'b0;
         beat_cnt <= 8'd0;
         err      <= 1'b0;
         ar_valid <= 1'b0;
         ar_addr  <= '0;
         ar_len   <= 8'd0;
         r_ready  <= 1'b0;
         busy     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (i_req || d_req) begin
                  owner_d  <= grant_d;
                  last_d   <= grant_d;
                  beat_cnt <= 8'd0;
                  ar_valid <= 1'b1;
                  busy     <= 1'b1;
                  state    <= ST_AR;
                  if (g_unc) begin
                     ar_addr <= g_addr;
                     ar_len  <= 8'd0;
                  end else begin
                     ar_addr <= {g_addr[ADDR_W-1:4], 4'b0000};
                     ar_len  <= LINE_LEN;
                  end
               end
            end
            ST_AR: begin
               if (ar_ready) begin
                  ar_valid <= 1'b0;
                  r_ready  <= 1'b1;
                  state    <= ST_R;
               end
            end
            ST_R: begin
               if (r_valid) begin
                  if (beat_cnt != 8'hFF) beat_cnt <= beat_cnt + 8'd1;
                  // r_last must coincide exactly with the beat numbered ar_len.
                  if (r_last != (beat_cnt == ar_len)) err <= 1'b1;
                  if (r_last) begin
                     r_ready <= 1'b0;
                     state   <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_refill_ctrl.sv
// Self-checking bench for axi_refill_ctrl: a small AXI read slave plus a
// transaction-level reference model (round-robin winner, line address, beat list).
module tb_axi_refill_ctrl;

   localparam int ADDR_W     = 32;
   localparam int LINE_BEATS = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              i_req, i_uncache, d_req, d_uncache;
   logic [ADDR_W-1:0] i_addr, d_addr;
   logic              i_ret_valid, i_ret_last, d_ret_valid, d_ret_last;
   logic [31:0]       ret_data;
   logic              ar_valid, ar_ready;
   logic [ADDR_W-1:0] ar_addr;
   logic [7:0]        ar_len;
   logic [2:0]        ar_size;
   logic              r_valid, r_last, r_ready;
   logic [31:0]       r_data;
   logic              busy, err;

   always #5 clk = ~clk;

   axi_refill_ctrl #(.ADDR_W(ADDR_W), .LINE_BEATS(LINE_BEATS)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_uncache(i_uncache),
      .d_req(d_req), .d_addr(d_addr), .d_uncache(d_uncache),
      .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last),
      .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last),
      .ret_data(ret_data),
      .ar_valid(ar_valid), .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size),
      .ar_ready(ar_ready),
      .r_valid(r_valid), .r_last(r_last), .r_data(r_data), .r_ready(r_ready),
      .busy(busy), .err(err)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0]       beat_q[$];
   logic              last_q[$];
   logic [31:0]       exp_q[$];
   logic [31:0]       got_data[$];
   logic [3:0]        got_flags[$];
   logic [ADDR_W-1:0] got_addr;
   logic [7:0]        got_len;
   logic [2:0]        got_size;
   int                stray, unstable, noready, n_iter, ar_seen_at;
   bit                timed_out;
   bit                model_last_d;
   bit                model_err;

   // Reference model: 1 means DCache wins.
   function automatic bit model_pick(input bit ir, input bit dr);
      if (ir && dr) return !model_last_d;
      return dr;
   endfunction

   function automatic logic [ADDR_W-1:0] model_addr(input logic [ADDR_W-1:0] a, input bit unc);
      return unc ? a : a - (a % 16);
   endfunction

   function automatic logic [7:0] model_len(input bit unc);
      return unc ? 8'd0 : 8'(LINE_BEATS - 1);
   endfunction

   function automatic logic [3:0] model_flags(input bit win_d, input bit last);
      return win_d ? {2'b00, 1'b1, last} : {1'b1, last, 2'b00};
   endfunction

   task automatic load_beats(input int n, input int last_at, input logic [7:0] len,
                             input bit fixed, input logic [31:0] base);
      beat_q.delete(); last_q.delete(); exp_q.delete();
      for (int k = 0; k < n; k++) begin
         logic [31:0] v;
         v = fixed ? base + 32'(k) : $urandom;
         beat_q.push_back(v);
         last_q.push_back(k == last_at);
         exp_q.push_back(v);
         if ((k == last_at) != (k == int'(len))) model_err = 1'b1;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; i_req = 1'b0; d_req = 1'b0; r_valid = 1'b0; ar_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_last_d = 1'b0;
      model_err    = 1'b0;
   endtask

   // AXI slave: accepts AR after ar_delay cycles, then plays beat_q with random gaps.
   task automatic serve(input int ar_delay, input int gap_max, input bit noise);
      int phase, w, bi;
      bit seen;
      phase = 0; w = 0; bi = 0; seen = 0;
      stray = 0; unstable = 0; noready = 0; n_iter = 0; ar_seen_at = 0; timed_out = 0;
      got_data.delete(); got_flags.delete();
      while (1) begin
         @(negedge clk);
         n_iter++;
         if (n_iter > 300) begin
            timed_out = 1; r_valid = 1'b0; ar_ready = 1'b0;
            return;
         end
         if (phase == 0) begin
            if (ar_valid) begin
               if (!seen) begin
                  seen = 1; ar_seen_at = n_iter;
                  got_addr = ar_addr; got_len = ar_len; got_size = ar_size;
               end else if (ar_addr !== got_addr || ar_len !== got_len) unstable++;
               ar_ready = (w >= ar_delay);
               w++;
               if (ar_ready) phase = 1;
            end else ar_ready = 1'b0;
            r_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            r_last  = 1'($urandom_range(0, 1));
            r_data  = $urandom;
            #1;
            if (i_ret_valid || d_ret_valid || i_ret_last || d_ret_last) stray++;
         end else begin
            ar_ready = 1'b0;
            if ($urandom_range(0, gap_max) == 0) begin
               r_valid = 1'b1; r_data = beat_q[bi]; r_last = last_q[bi]; bi++;
            end else begin
               r_valid = 1'b0; r_last = 1'($urandom_range(0, 1)); r_data = $urandom;
            end
            #1;
            if (r_valid) begin
               if (r_ready !== 1'b1) noready++;
               got_data.push_back(ret_data);
               got_flags.push_back({i_ret_valid, i_ret_last, d_ret_valid, d_ret_last});
               if (bi == beat_q.size()) return;
            end else if (i_ret_valid || d_ret_valid || i_ret_last || d_ret_last) stray++;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; i_req = 1'b1; d_req = 1'b1; r_valid = 1'b1; r_last = 1'b1;
      i_addr = $urandom; d_addr = $urandom; ar_ready = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         r_data = $urandom;
         #1;
         n_cmp++; if ({ar_valid, r_ready, busy, err} !== 4'b0000) begin n_bad++;
            $display("FAIL reset_ctl: got {ar_valid,r_ready,busy,err}=%b expected 0000", {ar_valid, r_ready, busy, err}); end
         n_cmp++; if (ar_addr !== '0 || ar_len !== 8'd0) begin n_bad++;
            $display("FAIL reset_ar: got addr %h len %0d expected 0/0", ar_addr, ar_len); end
         n_cmp++; if (ar_size !== 3'b010) begin n_bad++;
            $display("FAIL reset_size: got %b expected 010", ar_size); end
         n_cmp++; if ({i_ret_valid, i_ret_last, d_ret_valid, d_ret_last} !== 4'b0000) begin n_bad++;
            $display("FAIL reset_ret: got %b expected 0000", {i_ret_valid, i_ret_last, d_ret_valid, d_ret_last}); end
         n_cmp++; if (ret_data !== r_data) begin n_bad++;
            $display("FAIL reset_data: got %h expected %h", ret_data, r_data); end
      end
      rst = 1'b0; i_req = 1'b0; d_req = 1'b0; r_valid = 1'b0; r_last = 1'b0; ar_ready = 1'b0;
      model_last_d = 1'b0; model_err = 1'b0;
   endtask

   // Rows: cached ICache miss, uncached DCache read, minimum-latency cached DCache miss.
   task automatic test_directed();
      logic [ADDR_W-1:0] addrs[3];
      addrs = '{32'h1C000034, 32'hBFAF8004, 32'h0040123C};
      for (int row = 0; row < 3; row++) begin
         bit is_d, unc, win;
         logic [ADDR_W-1:0] e_addr;
         logic [7:0] e_len;
         int dly;
         is_d = (row != 0); unc = (row == 1); dly = (row == 0) ? 2 : 0;
         if (is_d) begin d_addr = addrs[row]; d_uncache = unc; d_req = 1'b1; end
         else begin i_addr = addrs[row]; i_uncache = unc; i_req = 1'b1; end
         win = model_pick(i_req, d_req); model_last_d = win;
         e_addr = model_addr(addrs[row], unc); e_len = model_len(unc);
         load_beats(int'(e_len) + 1, int'(e_len), e_len, row != 2, (row == 0) ? 32'hA0 : 32'h12345678);
         serve(dly, 0, 0);
         n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL dir_timeout: got %0d expected 0", timed_out); end
         n_cmp++; if (got_addr !== e_addr) begin n_bad++; $display("FAIL dir_ar_addr: got %h expected %h", got_addr, e_addr); end
         n_cmp++; if (got_len !== e_len) begin n_bad++; $display("FAIL dir_ar_len: got %0d expected %0d", got_len, e_len); end
         n_cmp++; if (got_size !== 3'b010) begin n_bad++; $display("FAIL dir_ar_size: got %b expected 010", got_size); end
         n_cmp++; if (unstable + stray + noready !== 0) begin n_bad++;
            $display("FAIL dir_proto: got unstable %0d stray %0d noready %0d expected 0", unstable, stray, noready); end
         n_cmp++; if (n_iter !== 1 + dly + int'(e_len) + 1) begin n_bad++;
            $display("FAIL dir_latency: got %0d cycles expected %0d", n_iter, 2 + dly + int'(e_len)); end
         n_cmp++; if (got_data.size() !== exp_q.size()) begin n_bad++;
            $display("FAIL dir_beats: got %0d expected %0d", got_data.size(), exp_q.size()); end
         for (int k = 0; k < got_data.size() && k < exp_q.size(); k++) begin
            n_cmp++; if (got_data[k] !== exp_q[k] || got_flags[k] !== model_flags(win, last_q[k])) begin n_bad++;
               $display("FAIL dir_beat%0d: got %h/%b expected %h/%b", k, got_data[k], got_flags[k], exp_q[k], model_flags(win, last_q[k])); end
         end
         @(negedge clk);
         r_valid = 1'b0; r_last = 1'b0;
         if (win) d_req = 1'b0; else i_req = 1'b0;
         n_cmp++; if ({busy, r_ready, ar_valid, err} !== {1'b1, 1'b0, 1'b0, model_err}) begin n_bad++;
            $display("FAIL dir_done: got {busy,r_ready,ar_valid,err}=%b expected %b", {busy, r_ready, ar_valid, err}, {3'b100, model_err}); end
         @(negedge clk);
         n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL dir_idle: got busy %b expected 0", busy); end
      end
   endtask

   task automatic test_arbitration();
      do_reset();
      i_addr = $urandom; d_addr = $urandom; i_uncache = 1'b0; d_uncache = 1'b0;
      i_req = 1'b1; d_req = 1'b1;
      for (int t = 0; t < 4; t++) begin
         bit win;
         logic [ADDR_W-1:0] e_addr;
         logic [7:0] e_len;
         win = model_pick(i_req, d_req); model_last_d = win;
         e_addr = model_addr(win ? d_addr : i_addr, 1'b0); e_len = model_len(1'b0);
         load_beats(int'(e_len) + 1, int'(e_len), e_len, 1'b0, 32'h0);
         serve($urandom_range(0, 3), 2, 1'b1);
         n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL arb_timeout: got %0d expected 0", timed_out); end
         n_cmp++; if (got_addr !== e_addr || got_len !== e_len) begin n_bad++;
            $display("FAIL arb_ar%0d: got %h/%0d expected %h/%0d", t, got_addr, got_len, e_addr, e_len); end
         n_cmp++; if (unstable + stray + noready !== 0 || ar_seen_at !== 1) begin n_bad++;
            $display("FAIL arb_proto%0d: got unstable %0d stray %0d noready %0d ar_at %0d expected 0/0/0/1", t, unstable, stray, noready, ar_seen_at); end
         n_cmp++; if (got_data.size() !== exp_q.size()) begin n_bad++;
            $display("FAIL arb_beats%0d: got %0d expected %0d", t, got_data.size(), exp_q.size()); end
         for (int k = 0; k < got_data.size() && k < exp_q.size(); k++) begin
            n_cmp++; if (got_data[k] !== exp_q[k] || got_flags[k] !== model_flags(win, last_q[k])) begin n_bad++;
               $display("FAIL arb_beat%0d_%0d: got %h/%b expected %h/%b", t, k, got_data[k], got_flags[k], exp_q[k], model_flags(win, last_q[k])); end
         end
         // Beats offered during the DONE bubble must be ignored.
         @(negedge clk);
         r_valid = 1'b1; r_last = 1'($urandom_range(0, 1));
         if (win) d_req = 1'b0; else i_req = 1'b0;
         #1;
         n_cmp++; if ({busy, r_ready, i_ret_valid, d_ret_valid} !== 4'b1000) begin n_bad++;
            $display("FAIL arb_done%0d: got {busy,r_ready,iv,dv}=%b expected 1000", t, {busy, r_ready, i_ret_valid, d_ret_valid}); end
         @(negedge clk);
         r_valid = 1'b0;
         n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL arb_idle%0d: got busy %b expected 0", t, busy); end
         if (t < 3) begin
            if (win) begin d_addr = $urandom; d_req = 1'b1; end
            else begin i_addr = $urandom; i_req = 1'b1; end
         end else begin
            i_req = 1'b0; d_req = 1'b0;
         end
      end
   endtask

   task automatic test_error_recovery();
      do_reset();
      for (int row = 0; row < 2; row++) begin
         bit win, unc;
         logic [ADDR_W-1:0] a, e_addr;
         logic [7:0] e_len;
         a = $urandom; unc = (row == 1);
         if (row == 0) begin i_addr = a; i_uncache = 1'b0; i_req = 1'b1; end
         else begin d_addr = a; d_uncache = 1'b1; d_req = 1'b1; end
         win = model_pick(i_req, d_req); model_last_d = win;
         e_addr = model_addr(a, unc); e_len = model_len(unc);
         // Row 0 ends the cached burst early on beat 1.
         load_beats((row == 0) ? 2 : 1, (row == 0) ? 1 : 0, e_len, 1'b0, 32'h0);
         serve(1, 0, 1'b0);
         n_cmp++; if (timed_out !== 1'b0 || got_addr !== e_addr || got_len !== e_len) begin n_bad++;
            $display("FAIL err_ar%0d: got %h/%0d to %0d expected %h/%0d to 0", row, got_addr, got_len, timed_out, e_addr, e_len); end
         n_cmp++; if (got_data.size() !== exp_q.size()) begin n_bad++;
            $display("FAIL err_beats%0d: got %0d expected %0d", row, got_data.size(), exp_q.size()); end
         for (int k = 0; k < got_data.size() && k < exp_q.size(); k++) begin
            n_cmp++; if (got_data[k] !== exp_q[k] || got_flags[k] !== model_flags(win, last_q[k])) begin n_bad++;
               $display("FAIL err_beat%0d_%0d: got %h/%b expected %h/%b", row, k, got_data[k], got_flags[k], exp_q[k], model_flags(win, last_q[k])); end
         end
         @(negedge clk);
         r_valid = 1'b0; r_last = 1'b0;
         if (win) d_req = 1'b0; else i_req = 1'b0;
         n_cmp++; if ({busy, r_ready, err} !== {2'b10, model_err}) begin n_bad++;
            $display("FAIL err_done%0d: got {busy,r_ready,err}=%b expected %b", row, {busy, r_ready, err}, {2'b10, model_err}); end
         @(negedge clk);
         n_cmp++; if ({busy, err} !== {1'b0, model_err}) begin n_bad++;
            $display("FAIL err_idle%0d: got {busy,err}=%b expected %b", row, {busy, err}, {1'b0, model_err}); end
      end
      // Reset while the R phase is in progress.
      i_addr = $urandom; i_uncache = 1'b0; i_req = 1'b1;
      begin
         int n;
         n = 0;
         do begin @(negedge clk); n++; end while (!ar_valid && n < 20);
         n_cmp++; if (ar_valid !== 1'b1) begin n_bad++; $display("FAIL rst_mid_ar: got ar_valid %b expected 1", ar_valid); end
      end
      ar_ready = 1'b1;
      @(negedge clk);
      ar_ready = 1'b0; r_valid = 1'b1; r_last = 1'b0; r_data = $urandom;
      #1;
      n_cmp++; if ({r_ready, i_ret_valid} !== 2'b11) begin n_bad++;
         $display("FAIL rst_mid_r: got {r_ready,iv}=%b expected 11", {r_ready, i_ret_valid}); end
      @(negedge clk);
      rst = 1'b1; i_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_cmp++; if ({busy, err, ar_valid, r_ready, i_ret_valid, d_ret_valid} !== 6'b0) begin n_bad++;
         $display("FAIL rst_mid_state: got {busy,err,ar_valid,r_ready,iv,dv}=%b expected 000000", {busy, err, ar_valid, r_ready, i_ret_valid, d_ret_valid}); end
      n_cmp++; if (ar_addr !== '0 || ar_len !== 8'd0) begin n_bad++;
         $display("FAIL rst_mid_ar_regs: got %h/%0d expected 0/0", ar_addr, ar_len); end
      r_valid = 1'b0;
      model_last_d = 1'b0; model_err = 1'b0;
   endtask

   task automatic test_random();
      do_reset();
      for (int it = 0; it < 12; it++) begin
         int p;
         p = $urandom_range(0, 2);
         i_addr = $urandom; d_addr = $urandom;
         i_uncache = 1'($urandom_range(0, 1)); d_uncache = 1'($urandom_range(0, 1));
         i_req = (p != 1); d_req = (p != 0);
         for (int j = 0; j < ((p == 2) ? 2 : 1); j++) begin
            bit win, unc;
            logic [ADDR_W-1:0] e_addr;
            logic [7:0] e_len;
            win = model_pick(i_req, d_req); model_last_d = win;
            unc = win ? d_uncache : i_uncache;
            e_addr = model_addr(win ? d_addr : i_addr, unc); e_len = model_len(unc);
            load_beats(int'(e_len) + 1, int'(e_len), e_len, 1'b0, 32'h0);
            serve($urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
            n_cmp++; if (timed_out !== 1'b0 || got_addr !== e_addr || got_len !== e_len || got_size !== 3'b010) begin n_bad++;
               $display("FAIL rnd_ar%0d_%0d: got %h/%0d/%b to %0d expected %h/%0d/010", it, j, got_addr, got_len, got_size, timed_out, e_addr, e_len); end
            n_cmp++; if (unstable + stray + noready !== 0 || ar_seen_at !== 1) begin n_bad++;
               $display("FAIL rnd_proto%0d_%0d: got unstable %0d stray %0d noready %0d ar_at %0d expected 0/0/0/1", it, j, unstable, stray, noready, ar_seen_at); end
            n_cmp++; if (got_data.size() !== exp_q.size()) begin n_bad++;
               $display("FAIL rnd_beats%0d_%0d: got %0d expected %0d", it, j, got_data.size(), exp_q.size()); end
            for (int k = 0; k < got_data.size() && k < exp_q.size(); k++) begin
               n_cmp++; if (got_data[k] !== exp_q[k] || got_flags[k] !== model_flags(win, last_q[k])) begin n_bad++;
                  $display("FAIL rnd_beat%0d_%0d_%0d: got %h/%b expected %h/%b", it, j, k, got_data[k], got_flags[k], exp_q[k], model_flags(win, last_q[k])); end
            end
            @(negedge clk);
            r_valid = 1'b0; r_last = 1'b0;
            if (win) d_req = 1'b0; else i_req = 1'b0;
            n_cmp++; if ({busy, r_ready, err} !== {2'b10, model_err}) begin n_bad++;
               $display("FAIL rnd_done%0d_%0d: got {busy,r_ready,err}=%b expected %b", it, j, {busy, r_ready, err}, {2'b10, model_err}); end
            @(negedge clk);
            n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rnd_idle%0d_%0d: got busy %b expected 0", it, j, busy); end
         end
      end
   endtask

   initial begin
      rst = 1'b1; i_req = 1'b0; d_req = 1'b0; i_addr = '0; d_addr = '0;
      i_uncache = 1'b0; d_uncache = 1'b0; ar_ready = 1'b0;
      r_valid = 1'b0; r_last = 1'b0; r_data = '0;
      test_reset();
      test_directed();
      test_arbitration();
      test_error_recovery();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/axi_refill_ctrl.md
# axi_refill_ctrl

Sequencing controller for the cache refill path: arbitrates between ICache and DCache miss/uncached-read requests for the single shared AXI read channel. It issues the AR burst, accepts R beats and forwards each beat, tagged valid/last, to the owning cache's return buffer. It sits between the two cache FSMs and the AXI bridge, one transaction in flight at a time.

## Interface
- ADDR_W, 32, address width
- LINE_BEATS, 4, 32-bit beats per cache line (line = 16 B)

- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- i_req  in  1  ICache read request; held until i_ret_last seen
- i_addr  in  ADDR_W  ICache request address; stable while i_req
- i_uncache  in  1  ICache request is uncached (single beat)
- d_req / d_addr / d_uncache  in  1 / ADDR_W / 1  same for DCache
- i_ret_valid, d_ret_valid  out  1  beat for that requester on ret_data this cycle
- i_ret_last, d_ret_last  out  1  final beat of that requester's transaction
- ret_data  out  32  shared beat data (combinational copy of r_data)
- ar_valid  out  1  AXI AR valid
- ar_addr  out  ADDR_W  AXI AR address
- ar_len  out  8  beats-1
- ar_size  out  3  fixed 3'b010 (4 B)
- ar_ready  in  1  AXI AR ready
- r_valid, r_last  in  1  AXI R valid / last
- r_data  in  32  AXI R data
- r_ready  out  1  AXI R ready
- busy  out  1  state != IDLE
- err  out  1  sticky protocol error, cleared only by rst

## Operation
- States: IDLE, AR, R, DONE. Registers: state, owner (I/D), last_grant, ar_addr, ar_len, beat_cnt, err.
- IDLE: req sampled only here. Only one requesting -> grant it. Both -> grant the one not equal to last_grant (round-robin); last_grant resets to I, so first contention goes to D. On grant: owner, last_grant <= winner; go AR.
- Address latch: cached -> ar_addr = addr with low 4 bits cleared, ar_len = LINE_BEATS-1; uncached -> ar_addr = addr unmodified, ar_len = 0. beat_cnt <= 0.
- AR: ar_valid=1; ar_addr/ar_len held stable until ar_valid&ar_ready; then go R.
- R: r_ready=1. Each r_valid beat: owner's ret_valid=1, ret_data=r_data, owner's ret_last=r_last (combinational, same cycle); beat_cnt++ (saturating at 255). Non-owner ret_valid/ret_last always 0. On r_last beat -> DONE.
- err set if r_last arrives with beat_cnt != ar_len, or a beat arrives with beat_cnt == ar_len and r_last=0 (that beat still forwarded with ret_last=0; wait for r_last).
- DONE: one-cycle bubble; req inputs ignored so the finished requester can drop req; -> IDLE.
- r_valid outside R: r_ready=0, ignored, no ret_valid.
- Reset (including mid-transaction): state IDLE, owner I, last_grant I, beat_cnt 0, err 0; in-flight AR/R abandoned (AXI side reset together).

## Timing
- Reset values: ar_valid 0, r_ready 0, ar_addr 0, ar_len 0, ar_size 3'b010, all ret_valid/ret_last 0, busy 0, err 0; ret_data follows r_data.
- req high in IDLE at cycle 0 -> ar_valid=1 at cycle 1.
- AR handshake at cycle k -> r_ready=1 from cycle k+1.
- ret_valid in the same cycle as r_valid&r_ready; zero-latency forward.
- r_last handshake at cycle m -> DONE at m+1 (busy=1, r_ready=0) -> IDLE at m+2; a pending request sampled at m+2 gives ar_valid at m+3.
- Minimum cached refill with ar_ready and r_valid always high: 1 + 1 + 4 + 1 = 7 cycles req-to-IDLE.

## Test plan
- Reset: assert rst 2 cycles with r_valid=1 -> all outputs at reset values, r_ready=0, no ret_valid.
- Cached ICache miss i_addr=0x1C000034, ar_ready after 2 cycles, 4 beats 0xA0..0xA3 back-to-back -> ar_addr=0x1C000030, ar_len=3, ar_size=2; i_ret_valid on 4 cycles with data A0..A3, i_ret_last only with A3, d_ret_valid never; IDLE 2 cycles after last.
- Uncached DCache d_addr=0xBFAF8004 -> ar_addr=0xBFAF8004, ar_len=0; one beat 0x12345678 with r_last -> d_ret_valid=d_ret_last=1 same cycle, err=0.
- i_req and d_req together from reset, both held and re-raised -> order D, I, D, I; gaps in r_valid (valid 1,0,0,1,...) stall forwarding without losing beats; r_valid during AR ignored.
- r_last on second beat of cached burst -> err=1, returns to IDLE via DONE; subsequent clean transaction keeps err=1; rst asserted in R state -> IDLE next cycle, err=0, ar_valid=0.
